// File: rtl/ts_bolucu_genel_if.sv
// Request/result handshake bundle for the iterative divider.
// The divider connects through the slave modport; the requester uses master.
interface ts_bolucu_genel_if #(
  parameter int GENISLIK = 32
);
  logic                istek_gecerli;
  logic                istek_hazir;
  logic [GENISLIK-1:0] bolunen;
  logic [GENISLIK-1:0] bolen;
  logic [1:0]          islem;
  logic                sonuc_gecerli;
  logic                sonuc_hazir;
  logic [GENISLIK-1:0] sonuc;

  modport master (
    output istek_gecerli, bolunen, bolen, islem, sonuc_hazir,
    input  istek_hazir, sonuc_gecerli, sonuc
  );

  modport slave (
    input  istek_gecerli, bolunen, bolen, islem, sonuc_hazir,
    output istek_hazir, sonuc_gecerli, sonuc
  );
endinterface

// File: rtl/ts_bolucu_genel.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, resolving
// ADIM_BIT quotient bits per cycle, with early-out and flush support.
module ts_bolucu_genel #(
  parameter int GENISLIK    = 32,
  parameter int ADIM_BIT    = 2,
  parameter bit ERKEN_CIKIS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iptal_i,
  output logic              mesgul_o,
  ts_bolucu_genel_if.slave  bus
);

  localparam int N  = GENISLIK / ADIM_BIT;
  localparam int SW = $clog2(N) + 1;
  localparam logic [GENISLIK-1:0] EN_NEGATIF = {1'b1, {(GENISLIK-1){1'b0}}};

  typedef enum logic [1:0] {BOS, HESAP, DUZELT, SONUC} durum_t;

  durum_t              durum, durum_sonraki;
  logic [SW-1:0]       sayac;
  logic [GENISLIK-1:0] bolum, kalan, bolen_mag, sonuc;
  logic                q_isaret, r_isaret, kalan_sec;

  // Acceptance-time decode of the raw operands
  logic                kabul, isaretli, a_neg, b_neg;
  logic [GENISLIK-1:0] a_mag, b_mag;
  logic                sifir_bolen, tasma, erken, ozel;
  logic [GENISLIK-1:0] ozel_sonuc;

  assign kabul    = bus.istek_gecerli & (durum == BOS) & ~iptal_i;
  assign isaretli = ~bus.islem[0];
  assign a_neg    = isaretli & bus.bolunen[GENISLIK-1];
  assign b_neg    = isaretli & bus.bolen[GENISLIK-1];
  assign a_mag    = a_neg ? -bus.bolunen : bus.bolunen;
  assign b_mag    = b_neg ? -bus.bolen   : bus.bolen;

  assign sifir_bolen = (bus.bolen == '0);
  assign tasma       = isaretli & (bus.bolunen == EN_NEGATIF) & (bus.bolen == '1);
  assign erken       = ERKEN_CIKIS & (a_mag < b_mag);
  assign ozel        = sifir_bolen | tasma | erken;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    ozel_sonuc = '0;
    if (sifir_bolen)
      ozel_sonuc = bus.islem[1] ? bus.bolunen : '1;
    else if (tasma)
      ozel_sonuc = bus.islem[1] ? '0 : EN_NEGATIF;
    else
      ozel_sonuc = bus.islem[1] ? bus.bolunen : '0;
  end

  // Shift-subtract chain: the trial remainder is one bit wider than the
  // divisor so the borrow is always bit GENISLIK, even for divisors >= 2^(GENISLIK-1).
  logic [GENISLIK-1:0] bolum_c, kalan_c;
  logic [GENISLIK:0]   kaydir, deneme;

  always_comb begin
    bolum_c = bolum;
    kalan_c = kalan;
    kaydir  = '0;
    deneme  = '0;
    // NOTE: blocking assignments here are intentional; each loop pass feeds the next within the same cycle.
    for (int i = 0; i < ADIM_BIT; i++) begin
      kaydir  = {kalan_c, bolum_c[GENISLIK-1]};
      deneme  = kaydir - {1'b0, bolen_mag};
      bolum_c = {bolum_c[GENISLIK-2:0], ~deneme[GENISLIK]};
      kalan_c = deneme[GENISLIK] ? kaydir[GENISLIK-1:0] : deneme[GENISLIK-1:0];
    end
  end

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOS:     if (kabul) durum_sonraki = ozel ? SONUC : HESAP;
      HESAP:   if (sayac == SW'(1)) durum_sonraki = DUZELT;
      DUZELT:  durum_sonraki = SONUC;
      SONUC:   if (bus.sonuc_hazir) durum_sonraki = BOS;
      default: durum_sonraki = BOS;
    endcase
    if (iptal_i) durum_sonraki = BOS;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) durum <= BOS;
    else       durum <= durum_sonraki;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac     <= '0;
      bolum     <= '0;
      kalan     <= '0;
      bolen_mag <= '0;
      sonuc     <= '0;
      q_isaret  <= 1'b0;
      r_isaret  <= 1'b0;
      kalan_sec <= 1'b0;
    end else if (!iptal_i) begin
      case (durum)
        BOS: if (kabul) begin
          bolum     <= a_mag;
          kalan     <= '0;
          bolen_mag <= b_mag;
          sayac     <= SW'(N);
          q_isaret  <= a_neg ^ b_neg;
          r_isaret  <= a_neg;
          kalan_sec <= bus.islem[1];
          if (ozel) sonuc <= ozel_sonuc;
        end
        HESAP: begin
          bolum <= bolum_c;
          kalan <= kalan_c;
          sayac <= sayac - SW'(1);
        end
        DUZELT: begin
          if (kalan_sec) sonuc <= r_isaret ? -kalan : kalan;
          else           sonuc <= q_isaret ? -bolum : bolum;
        end
        default: ;
      endcase
    end
  end

  assign bus.istek_hazir   = (durum == BOS);
  assign bus.sonuc_gecerli = (durum == SONUC);
  assign bus.sonuc         = sonuc;
  assign mesgul_o          = (durum != BOS);

endmodule

// File: tb/tb_ts_bolucu_genel.sv
// Directed bench: two 32-bit dividers (early-out on/off) fed the same
// stimulus, plus a 16-bit/8-bit-step instance against a reference model.
module tb_ts_bolucu_genel;

  logic clk_i = 1'b0;
  logic rst_i, iptal_i;
  logic m1, m2, m3;

  logic        istek_gecerli, sonuc_hazir;
  logic [31:0] bolunen, bolen;
  logic [1:0]  islem;

  int gecen  = 0;
  int toplam = 0;

  always #5 clk_i = ~clk_i;

  ts_bolucu_genel_if #(.GENISLIK(32)) b1 ();
  ts_bolucu_genel_if #(.GENISLIK(32)) b2 ();
  ts_bolucu_genel_if #(.GENISLIK(16)) b3 ();

  assign b1.istek_gecerli = istek_gecerli;
  assign b1.bolunen       = bolunen;
  assign b1.bolen         = bolen;
  assign b1.islem         = islem;
  assign b1.sonuc_hazir   = sonuc_hazir;
  assign b2.istek_gecerli = istek_gecerli;
  assign b2.bolunen       = bolunen;
  assign b2.bolen         = bolen;
  assign b2.islem         = islem;
  assign b2.sonuc_hazir   = sonuc_hazir;

  ts_bolucu_genel #(.GENISLIK(32), .ADIM_BIT(2), .ERKEN_CIKIS(1'b1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .iptal_i(iptal_i), .mesgul_o(m1), .bus(b1));
  ts_bolucu_genel #(.GENISLIK(32), .ADIM_BIT(2), .ERKEN_CIKIS(1'b0)) u_dut_ec0 (
    .clk_i(clk_i), .rst_i(rst_i), .iptal_i(iptal_i), .mesgul_o(m2), .bus(b2));
  ts_bolucu_genel #(.GENISLIK(16), .ADIM_BIT(8), .ERKEN_CIKIS(1'b1)) u_dut16 (
    .clk_i(clk_i), .rst_i(rst_i), .iptal_i(iptal_i), .mesgul_o(m3), .bus(b3));

  task automatic check(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
    toplam++;
    assert (gozlenen === beklenen) gecen++;
    else $error("FAIL %s: observed=%0h expected=%0h", etiket, gozlenen, beklenen);
  endtask

  // Runs one request on both 32-bit DUTs; latency counts the acceptance edge as 1.
  task automatic calistir(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] s1, output int l1,
                          output logic [31:0] s2, output int l2);
    bit g1, g2;
    g1 = 1'b0; g2 = 1'b0; l1 = -1; l2 = -1; s1 = '0; s2 = '0;
    istek_gecerli = 1'b1; islem = op; bolunen = a; bolen = b; sonuc_hazir = 1'b0;
    @(posedge clk_i); #1;
    istek_gecerli = 1'b0; bolunen = ~a; bolen = a ^ b; islem = ~op;
    for (int k = 1; k <= 40 && !(g1 && g2); k++) begin
      if (!g1 && b1.sonuc_gecerli) begin g1 = 1'b1; l1 = k; s1 = b1.sonuc; end
      if (!g2 && b2.sonuc_gecerli) begin g2 = 1'b1; l2 = k; s2 = b2.sonuc; end
      if (!(g1 && g2)) begin @(posedge clk_i); #1; end
    end
    sonuc_hazir = 1'b1;
    @(posedge clk_i); #1;
    sonuc_hazir = 1'b0;
  endtask

  task automatic adim(input string ad, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] beklenen, input int lat1, input int lat2);
    logic [31:0] s1, s2;
    int l1, l2;
    calistir(op, a, b, s1, l1, s2, l2);
    check({ad, "_sonuc"}, s1, beklenen);
    check({ad, "_gecikme"}, l1, lat1);
    check({ad, "_sonuc_ec0"}, s2, beklenen);
    check({ad, "_gecikme_ec0"}, l2, lat2);
  endtask

  task automatic calistir3(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] s, output int l);
    bit g;
    g = 1'b0; l = -1; s = '0;
    b3.istek_gecerli = 1'b1; b3.islem = op; b3.bolunen = a; b3.bolen = b; b3.sonuc_hazir = 1'b0;
    @(posedge clk_i); #1;
    b3.istek_gecerli = 1'b0; b3.bolunen = ~a;
    for (int k = 1; k <= 20 && !g; k++) begin
      if (b3.sonuc_gecerli) begin g = 1'b1; l = k; s = b3.sonuc; end
      else begin @(posedge clk_i); #1; end
    end
    b3.sonuc_hazir = 1'b1;
    @(posedge clk_i); #1;
    b3.sonuc_hazir = 1'b0;
  endtask

  function automatic logic [15:0] ref16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa, sb;
    logic tas;
    sa  = a;
    sb  = b;
    tas = (a == 16'h8000) && (b == 16'hFFFF);
    case (op)
      2'b00:   return (b == 0) ? 16'hFFFF : tas ? 16'h8000 : 16'(sa / sb);
      2'b01:   return (b == 0) ? 16'hFFFF : a / b;
      2'b10:   return (b == 0) ? a : tas ? 16'h0000 : 16'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] am, bm;
    am = (!op[0] && a[15]) ? -a : a;
    bm = (!op[0] && b[15]) ? -b : b;
    if (b == 0 || (!op[0] && a == 16'h8000 && b == 16'hFFFF) || am < bm) return 1;
    return 4;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s3, a3, d3;
    logic [1:0]  op3;
    int          l3, goruldu;
    bit          geldi;

    rst_i = 1'b1; iptal_i = 1'b0;
    istek_gecerli = 1'b0; sonuc_hazir = 1'b0; bolunen = '0; bolen = '0; islem = '0;
    b3.istek_gecerli = 1'b0; b3.sonuc_hazir = 1'b0; b3.bolunen = '0; b3.bolen = '0; b3.islem = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    check("rst_istek_hazir", b1.istek_hazir, 1);
    check("rst_sonuc_gecerli", b1.sonuc_gecerli, 0);
    check("rst_sonuc", b1.sonuc, 0);
    check("rst_mesgul", m1, 0);

    adim("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         18, 18);
    adim("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          18, 18);
    adim("div_m100_7",   2'b00, -32'sd100,      32'd7,          -32'sd14,       18, 18);
    adim("rem_m100_7",   2'b10, -32'sd100,      32'd7,          -32'sd2,        18, 18);
    adim("rem_100_m7",   2'b10, 32'd100,        -32'sd7,        32'd2,          18, 18);
    adim("div_7_m2",     2'b00, 32'd7,          -32'sd2,        -32'sd3,        18, 18);
    adim("rem_m7_m2",    2'b10, -32'sd7,        -32'sd2,        -32'sd1,        18, 18);
    adim("divu_genis",   2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          18, 18);
    adim("remu_genis",   2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE, 18, 18);
    adim("div_sifir",    2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1);
    adim("rem_sifir",    2'b10, 32'd5,          32'd0,          32'd5,          1,  1);
    adim("div_tasma",    2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1);
    adim("rem_tasma",    2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1);
    adim("div_erken",    2'b00, -32'sd3,        32'd10,         32'd0,          1,  18);
    adim("rem_erken",    2'b10, -32'sd3,        32'd10,         -32'sd3,        1,  18);
    adim("divu_min_m1",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  18);
    adim("remu_min_m1",  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  18);

    // Back-pressure: result held, new requests ignored while waiting
    istek_gecerli = 1'b1; islem = 2'b01; bolunen = 32'd100; bolen = 32'd7; sonuc_hazir = 1'b0;
    @(posedge clk_i); #1;
    istek_gecerli = 1'b0;
    geldi = 1'b0;
    for (int k = 0; k < 40 && !geldi; k++) begin
      if (b1.sonuc_gecerli) geldi = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("tut_bekle", geldi, 1);
    istek_gecerli = 1'b1; islem = 2'b01; bolunen = 32'd50; bolen = 32'd3;
    repeat (10) begin
      @(posedge clk_i); #1;
      check("tut_gecerli", b1.sonuc_gecerli, 1);
      check("tut_sonuc", b1.sonuc, 32'd14);
      check("tut_istek_hazir", b1.istek_hazir, 0);
    end
    istek_gecerli = 1'b0; sonuc_hazir = 1'b1;
    @(posedge clk_i); #1;
    sonuc_hazir = 1'b0;
    check("tut_sonra_gecerli", b1.sonuc_gecerli, 0);
    check("tut_sonra_hazir", b1.istek_hazir, 1);
    check("tut_sonra_hazir_ec0", b2.istek_hazir, 1);

    // Consumer already ready: valid lasts exactly one cycle
    sonuc_hazir = 1'b1;
    istek_gecerli = 1'b1; islem = 2'b00; bolunen = 32'd5; bolen = 32'd0;
    @(posedge clk_i); #1;
    istek_gecerli = 1'b0;
    check("tek_gecerli", b1.sonuc_gecerli, 1);
    check("tek_sonuc", b1.sonuc, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    sonuc_hazir = 1'b0;
    check("tek_sonra_gecerli", b1.sonuc_gecerli, 0);
    check("tek_sonra_hazir", b1.istek_hazir, 1);

    // Request together with flush is not accepted
    istek_gecerli = 1'b1; iptal_i = 1'b1; islem = 2'b01; bolunen = 32'd100; bolen = 32'd7;
    @(posedge clk_i); #1;
    istek_gecerli = 1'b0; iptal_i = 1'b0;
    check("iptal_kabul_yok_hazir", b1.istek_hazir, 1);
    check("iptal_kabul_yok_mesgul", m1, 0);

    // Flush in the fifth HESAP cycle
    istek_gecerli = 1'b1;
    @(posedge clk_i); #1;
    istek_gecerli = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    check("iptal_once_mesgul", m1, 1);
    iptal_i = 1'b1;
    @(posedge clk_i); #1;
    iptal_i = 1'b0;
    check("iptal_hazir", b1.istek_hazir, 1);
    check("iptal_gecerli", b1.sonuc_gecerli, 0);
    check("iptal_mesgul", m1, 0);
    goruldu = 0;
    repeat (25) begin
      @(posedge clk_i); #1;
      if (b1.sonuc_gecerli || b2.sonuc_gecerli) goruldu++;
    end
    check("iptal_sonuc_yok", goruldu, 0);

    // Reset while in DUZELT
    istek_gecerli = 1'b1; islem = 2'b01; bolunen = 32'd100; bolen = 32'd7;
    @(posedge clk_i); #1;
    istek_gecerli = 1'b0;
    repeat (16) @(posedge clk_i);
    #1;
    check("duzelt_mesgul", m1, 1);
    check("duzelt_gecerli", b1.sonuc_gecerli, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst2_istek_hazir", b1.istek_hazir, 1);
    check("rst2_sonuc_gecerli", b1.sonuc_gecerli, 0);
    check("rst2_sonuc", b1.sonuc, 0);
    check("rst2_mesgul", m1, 0);
    check("rst2_sonuc_ec0", b2.sonuc, 0);

    // 16-bit, 8 bits per cycle
    calistir3(2'b00, 16'h8000, 16'hFFFF, s3, l3);
    check("g16_tasma_sonuc", s3, 16'h8000);
    check("g16_tasma_gecikme", l3, 1);
    calistir3(2'b01, 16'hFFFF, 16'h8001, s3, l3);
    check("g16_genis_sonuc", s3, 16'd1);
    check("g16_genis_gecikme", l3, 4);
    calistir3(2'b11, 16'hFFFF, 16'h8001, s3, l3);
    check("g16_genis_kalan", s3, 16'h7FFE);
    for (int i = 0; i < 40; i++) begin
      op3 = 2'($urandom_range(0, 3));
      a3  = 16'($urandom);
      d3  = (i % 8 == 7) ? 16'h0000 : 16'(16'($urandom) >> $urandom_range(4, 15));
      calistir3(op3, a3, d3, s3, l3);
      check("g16_rastgele_sonuc", s3, ref16(op3, a3, d3));
      check("g16_rastgele_gecikme", l3, lat16(op3, a3, d3));
    end

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule

// File: doc/ts_bolucu_genel.md
# ts_bolucu_genel

Parametrised iterative integer divider for the execute stage: computes RISC-V M-extension DIV, DIVU, REM and REMU on GENISLIK-bit operands and retires ADIM_BIT quotient bits per cycle. It has valid/ready request and result handshakes, an optional early-out path and a flush input. It is the drop-in successor of the fixed 32-bit divider behind the execute-stage M-unit arbiter.

## Interface
- GENISLIK, 32: operand/result width; ≥ 8.
- ADIM_BIT, 2: quotient bits resolved per cycle; must divide GENISLIK; legal values 1, 2, 4, 8.
- ERKEN_CIKIS, 1: 1 enables the |bolunen| < |bolen| early-out; 0 always iterates.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- istek_gecerli_i  input  1  request valid.
- istek_hazir_o  output  1  request ready; high only in BOS.
- bolunen_i  input  GENISLIK  dividend.
- bolen_i  input  GENISLIK  divisor.
- islem_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- iptal_i  input  1  flush; aborts any in-flight operation.
- sonuc_gecerli_o  output  1  result valid.
- sonuc_hazir_i  input  1  consumer ready.
- sonuc_o  output  GENISLIK  quotient (DIV/DIVU) or remainder (REM/REMU).
- mesgul_o  output  1  high in any state other than BOS.

## Operation
- States: BOS, HESAP, DUZELT, SONUC.
- Acceptance: istek_gecerli_i & istek_hazir_o & !iptal_i at a rising edge. Operands and islem_i are latched at that edge; later input changes have no effect.
- On acceptance, with signed = !islem_i[0]:
  - Compute magnitudes. Store the quotient sign (signed & sign(bolunen) ^ sign(bolen)) and the remainder sign (signed & sign(bolunen)).
  - The special cases below are checked in priority order and go BOS→SONUC. Otherwise the next state is HESAP.
- Divide by zero (bolen = 0): quotient = all ones; remainder = bolunen unchanged.
- Signed overflow (DIV/REM, bolunen = most-negative, bolen = all ones): quotient = most-negative (1 followed by GENISLIK-1 zeros); remainder = 0.
- Early-out (ERKEN_CIKIS=1 and |bolunen| < |bolen|): quotient = 0; remainder = bolunen unchanged.
- HESAP: restoring division using GENISLIK/ADIM_BIT iterations.
  - The partial remainder is GENISLIK+1 bits. Trial-subtract borrow is taken from bit GENISLIK, never from bit GENISLIK-1, so divisors ≥ 2^(GENISLIK-1) divide correctly.
  - ADIM_BIT shift-subtract steps are chained combinationally per cycle.
  - A down-counter of width clog2(GENISLIK/ADIM_BIT)+1 is loaded with GENISLIK/ADIM_BIT. The state moves to DUZELT when it reaches 0.
- DUZELT: negate the quotient and/or remainder per the stored signs (two's complement, truncated to GENISLIK). Select the result by islem_i[1] and register it into sonuc_o. Next state is SONUC.
- SONUC: sonuc_gecerli_o = 1 and sonuc_o is held stable until sonuc_gecerli_o & sonuc_hazir_i. That edge moves the state to BOS.
- iptal_i: highest priority after reset.
  - In any state, the next state is BOS and sonuc_gecerli_o is 0 from the next cycle. No result is emitted.
  - A request presented in the same cycle as iptal_i is not accepted.

## Timing
- Reset values: istek_hazir_o=1 (BOS), sonuc_gecerli_o=0, sonuc_o=0, mesgul_o=0; counter and internal registers are 0.
- rst_i asserted mid-operation abandons the operation with no result; the state is BOS on the next cycle.
- With N = GENISLIK/ADIM_BIT and acceptance at edge T:
  - HESAP spans cycles T..T+N-1.
  - DUZELT is in cycle T+N.
  - sonuc_gecerli_o rises after edge T+N+1, giving acceptance-to-valid latency N+2 cycles.
- Special cases: sonuc_gecerli_o is high in the cycle after the acceptance edge (latency 1).
- Result handshake: if sonuc_hazir_i is already high, sonuc_gecerli_o stays up exactly 1 cycle. Back-pressure holds it indefinitely with sonuc_o stable.
- Throughput: istek_hazir_o returns the cycle after the result handshake. Back-to-back requests cannot overlap.
- istek_hazir_o and sonuc_gecerli_o are registered-state decodes; neither depends combinationally on istek_gecerli_i or sonuc_hazir_i.

## Test plan
- Default parameters: DIVU 100/7 -> sonuc_o=14 exactly 18 cycles after acceptance. REMU 100/7 -> 2. DIV −100/7 -> −14. REM −100/7 -> −2. REM 100/−7 -> 2.
- DIVU 0xFFFFFFFF/0x80000001 -> 1; REMU of the same operands -> 0x7FFFFFFE. Checks the wide-divisor borrow path.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Each is valid 1 cycle after acceptance.
- Early-out: DIV −3/10 -> 0 and REM −3/10 -> −3, 1-cycle latency. With ERKEN_CIKIS=0 the same values arrive at 18 cycles.
- Hold sonuc_hazir_i=0 for 10 cycles -> sonuc_o stable and istek_gecerli_i ignored. Pulse iptal_i in HESAP cycle 5 -> no sonuc_gecerli_o and istek_hazir_o=1 the next cycle. Assert rst_i in DUZELT -> all outputs at reset values next cycle.
- Sweep ADIM_BIT ∈ {1,4,8} with GENISLIK ∈ {16,32,64} using 10k random signed/unsigned operands against a reference model. Latency must equal GENISLIK/ADIM_BIT+2 for non-special cases.
